// File: rtl/sctag_vd_lru_way.sv
// ----------------------------------------------------------------------------
// sctag_vd_lru_way
//
// Victim-way selector for the L2 tag pipeline (12 ways). In C2 it combines the
// valid bits from the VD datapath with used/alloc state and a per-way disable.
// It then registers a one-hot victim way into C3, along with an eviction
// qualifier. A round-robin pointer sets where each circular search starts, and
// it advances past the way picked on every successful pick.
//
// Ports:
//   rclk              clock, rising edge
//   arst_l            asynchronous active-low reset
//   se, si            scan enable / scan in (no functional effect)
//   so                scan out, tied low
//   lru_req_c2        C2 miss needs a victim way
//   vuad_dp_valid_c2  per-way valid bits from the VD datapath
//   used_c2           per-way used bits from the UA datapath
//   alloc_c2          per-way fill-pending bits (never picked)
//   cfg_way_dis       per-way disable (never picked)
//   lru_way_c3        registered one-hot victim way, 0 if none picked
//   vuad_evict_c3     picked way held valid data
//   no_way_avail_c3   request made but no candidate way existed
//   lru_ptr           round-robin search start pointer
// ----------------------------------------------------------------------------
module sctag_vd_lru_way (
    input  logic        rclk,
    input  logic        arst_l,
    input  logic        se,
    input  logic        si,
    output logic        so,
    input  logic        lru_req_c2,
    input  logic [11:0] vuad_dp_valid_c2,
    input  logic [11:0] used_c2,
    input  logic [11:0] alloc_c2,
    input  logic [11:0] cfg_way_dis,
    output logic [11:0] lru_way_c3,
    output logic        vuad_evict_c3,
    output logic        no_way_avail_c3,
    output logic [3:0]  lru_ptr
);

    // Scan pins carry no function in this block.
    logic unused_scan;
    assign unused_scan = se ^ si;
    assign so          = 1'b0;

    // Returns {found, index} of the first set bit of vec, searched from
    // index start upwards and wrapping from 11 back to 0.
    function automatic logic [4:0] circ_first(input logic [11:0] vec,
                                              input logic [3:0]  start);
        logic        found;
        logic [3:0]  sel;
        int unsigned pos;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            pos = 32'(start) + i;
            if (pos >= 12) pos = pos - 12;
            if (!found && vec[pos[3:0]]) begin
                found = 1'b1;
                sel   = pos[3:0];
            end
        end
        return {found, sel};
    endfunction

    logic [11:0] cand;
    logic [11:0] tier_invalid;
    logic [11:0] tier_unused;
    logic [11:0] tier_valid;
    logic [3:0]  search_start;
    logic [4:0]  hit_invalid;
    logic [4:0]  hit_unused;
    logic [4:0]  hit_valid;
    logic        pick_found;
    logic [3:0]  pick_idx;
    logic        pick_evict;
    logic [11:0] pick_onehot;
    logic [3:0]  ptr_next;

    always_comb begin
        cand         = ~alloc_c2 & ~cfg_way_dis;
        tier_invalid = cand & ~vuad_dp_valid_c2;
        tier_unused  = cand &  vuad_dp_valid_c2 & ~used_c2;
        tier_valid   = cand &  vuad_dp_valid_c2;

        // An illegal pointer (12..15) starts the search at way 0.
        search_start = (lru_ptr > 4'd11) ? 4'd0 : lru_ptr;

        hit_invalid = circ_first(tier_invalid, search_start);
        hit_unused  = circ_first(tier_unused,  search_start);
        hit_valid   = circ_first(tier_valid,   search_start);

        pick_found = 1'b0;
        pick_idx   = '0;
        pick_evict = 1'b0;
        if (hit_invalid[4]) begin
            pick_found = 1'b1;
            pick_idx   = hit_invalid[3:0];
        end else if (hit_unused[4]) begin
            pick_found = 1'b1;
            pick_idx   = hit_unused[3:0];
            pick_evict = 1'b1;
        end else if (hit_valid[4]) begin
            pick_found = 1'b1;
            pick_idx   = hit_valid[3:0];
            pick_evict = 1'b1;
        end

        pick_onehot = pick_found ? (12'b1 << pick_idx) : '0;
        ptr_next    = (pick_idx == 4'd11) ? 4'd0 : pick_idx + 4'd1;
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            lru_way_c3      <= '0;
            vuad_evict_c3   <= 1'b0;
            no_way_avail_c3 <= 1'b0;
            lru_ptr         <= '0;
        end else begin
            lru_way_c3      <= lru_req_c2 ? pick_onehot : '0;
            vuad_evict_c3   <= lru_req_c2 & pick_evict;
            no_way_avail_c3 <= lru_req_c2 & ~pick_found;
            if (lru_req_c2 && pick_found) begin
                lru_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_sctag_vd_lru_way.sv
// ----------------------------------------------------------------------------
// tb_sctag_vd_lru_way
//
// Directed-vector bench for sctag_vd_lru_way. The driver applies C2 inputs on
// the falling edge and queues the hand-computed C3 response. A monitor pops
// that response just after the next rising edge and compares it.
// ----------------------------------------------------------------------------
module tb_sctag_vd_lru_way;

    logic        rclk;
    logic        arst_l;
    logic        se;
    logic        si;
    logic        so;
    logic        lru_req_c2;
    logic [11:0] vuad_dp_valid_c2;
    logic [11:0] used_c2;
    logic [11:0] alloc_c2;
    logic [11:0] cfg_way_dis;
    logic [11:0] lru_way_c3;
    logic        vuad_evict_c3;
    logic        no_way_avail_c3;
    logic [3:0]  lru_ptr;

    sctag_vd_lru_way dut (
        .rclk             (rclk),
        .arst_l           (arst_l),
        .se               (se),
        .si               (si),
        .so               (so),
        .lru_req_c2       (lru_req_c2),
        .vuad_dp_valid_c2 (vuad_dp_valid_c2),
        .used_c2          (used_c2),
        .alloc_c2         (alloc_c2),
        .cfg_way_dis      (cfg_way_dis),
        .lru_way_c3       (lru_way_c3),
        .vuad_evict_c3    (vuad_evict_c3),
        .no_way_avail_c3  (no_way_avail_c3),
        .lru_ptr          (lru_ptr)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        string       name;
        logic [11:0] way;
        logic        evict;
        logic        nwa;
        logic [3:0]  ptr;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void chk(string name, logic [11:0] act, logic [11:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, expv);
    endfunction

    // Monitor: compares the queued response one step after each rising edge.
    exp_t e;
    always @(posedge rclk) begin
        #1;
        if (arst_l && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".way"},   lru_way_c3,              e.way);
            chk({e.name, ".evict"}, {11'b0, vuad_evict_c3},   {11'b0, e.evict});
            chk({e.name, ".nwa"},   {11'b0, no_way_avail_c3}, {11'b0, e.nwa});
            chk({e.name, ".ptr"},   {8'b0, lru_ptr},          {8'b0, e.ptr});
        end
    end

    task automatic issue(input string name, input logic req,
                         input logic [11:0] v, input logic [11:0] u,
                         input logic [11:0] a, input logic [11:0] d,
                         input logic [11:0] ew, input logic ee,
                         input logic en, input logic [3:0] ep);
        exp_t x;
        @(negedge rclk);
        lru_req_c2       = req;
        vuad_dp_valid_c2 = v;
        used_c2          = u;
        alloc_c2         = a;
        cfg_way_dis      = d;
        x.name  = name;
        x.way   = ew;
        x.evict = ee;
        x.nwa   = en;
        x.ptr   = ep;
        exp_q.push_back(x);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, ".way"},   lru_way_c3,                12'h000);
        chk({name, ".evict"}, {11'b0, vuad_evict_c3},    12'h000);
        chk({name, ".nwa"},   {11'b0, no_way_avail_c3},  12'h000);
        chk({name, ".ptr"},   {8'b0, lru_ptr},           12'h000);
        chk({name, ".so"},    {11'b0, so},               12'h000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_l           = 1'b0;
        se               = 1'b0;
        si               = 1'b0;
        lru_req_c2       = 1'b0;
        vuad_dp_valid_c2 = '0;
        used_c2          = '0;
        alloc_c2         = '0;
        cfg_way_dis      = '0;

        repeat (3) @(posedge rclk);
        #2;
        chk_reset_state("reset");
        @(negedge rclk);
        arst_l = 1'b1;

        //    name        req valid    used     alloc    dis      way      ev nwa ptr
        issue("allv0",    1, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h001, 1, 0, 4'd1);
        issue("allv1",    1, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h002, 1, 0, 4'd2);
        issue("invwrap",  1, 12'hFFE, 12'h000, 12'h000, 12'h000, 12'h001, 0, 0, 4'd1);
        issue("invfirst", 1, 12'hFF7, 12'hFFF, 12'h000, 12'h000, 12'h008, 0, 0, 4'd4);
        issue("to11",     1, 12'hBFF, 12'hFFF, 12'h000, 12'h000, 12'h400, 0, 0, 4'd11);
        issue("unused10", 1, 12'hFFF, 12'hBFF, 12'h000, 12'h000, 12'h400, 1, 0, 4'd11);
        issue("unused11", 1, 12'hFFF, 12'h7FF, 12'h000, 12'h000, 12'h800, 1, 0, 4'd0);
        issue("mask",     1, 12'hFFF, 12'hFFF, 12'h00F, 12'h030, 12'h040, 1, 0, 4'd7);
        issue("noway",    1, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 0, 1, 4'd7);
        issue("only11",   1, 12'hFFF, 12'hFFF, 12'h7FF, 12'h000, 12'h800, 1, 0, 4'd0);
        issue("b2b0",     1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h001, 0, 0, 4'd1);
        issue("b2b1",     1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h002, 0, 0, 4'd2);
        issue("idle",     0, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 0, 4'd2);
        issue("b2b2",     1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h004, 0, 0, 4'd3);
        issue("disused",  1, 12'hFFF, 12'hFF7, 12'h000, 12'h008, 12'h010, 1, 0, 4'd5);
        issue("pre_rst",  1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h020, 0, 0, 4'd6);

        // Assert reset between edges with a request still pending; outputs
        // must clear before any further clock edge.
        @(posedge rclk);
        #3;
        arst_l     = 1'b0;
        lru_req_c2 = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(posedge rclk);
        #1;
        chk_reset_state("held_rst");
        @(negedge rclk);
        lru_req_c2 = 1'b0;
        #1;
        arst_l = 1'b1;

        issue("post_rst", 1, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h001, 1, 0, 4'd1);
        issue("tail",     0, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 0, 4'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge rclk);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
